// File: rtl/fp16_mpy_feeder.sv
// Operand FIFO + registered product stage in front of the combinational fp16 multiplier.
// Define FEEDER_STATS_EN to build the op_count / nan_count statistics counters.
module fp16_mpy_feeder #(
    parameter int unsigned DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_a,
    input  logic [15:0] in_b,
    output logic [15:0] mpy_a,
    output logic [15:0] mpy_b,
    input  logic [15:0] mpy_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_p,
    output logic [3:0]  out_flags,
    output logic [15:0] op_count,
    output logic [7:0]  nan_count
);

    localparam int unsigned FP_W      = 16;
    localparam int unsigned EXP_W     = 5;
    localparam int unsigned MAN_W     = 10;
    localparam int unsigned FLAG_W    = 4;
    localparam int unsigned OP_CNT_W  = 16;
    localparam int unsigned NAN_CNT_W = 8;
    localparam int unsigned PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W     = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
    } pair_t;

    // {nan, inf, zero, sub}; the four classes are mutually exclusive
    function automatic logic [FLAG_W-1:0] classify(input logic [EXP_W-1:0] e,
                                                   input logic [MAN_W-1:0] m);
        logic e_max;
        logic e_min;
        logic m_nz;
        e_max = (e == {EXP_W{1'b1}});
        e_min = (e == '0);
        m_nz  = (m != '0);
        classify = {e_max & m_nz, e_max & ~m_nz, e_min & ~m_nz, e_min & m_nz};
    endfunction

    pair_t              mem_q [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               out_valid_q, out_valid_d;
    logic [FP_W-1:0]    out_p_q, out_p_d;
    logic [FLAG_W-1:0]  out_flags_q, out_flags_d;

    logic               fifo_empty;
    logic               push;
    logic               issue;
    pair_t              head;

    // FIFO status and the two transfer strobes
    always_comb begin
        fifo_empty = (count_q == '0);
        in_ready   = (count_q != CNT_W'(DEPTH));
        push       = in_valid && in_ready;
        issue      = !fifo_empty && (!out_valid_q || out_ready);
        head       = mem_q[rd_ptr_q];
    end

    // Head operands are masked to zero while empty so stale storage never reaches the multiplier
    assign mpy_a = fifo_empty ? '0 : head.a;
    assign mpy_b = fifo_empty ? '0 : head.b;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= pair_t'({in_a, in_b});
        end
    end

    // Pointer and occupancy update
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (issue) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, issue})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Product register: load on issue, release on a handshake with nothing behind it
    always_comb begin
        out_valid_d = out_valid_q;
        out_p_d     = out_p_q;
        out_flags_d = out_flags_q;
        if (issue) begin
            out_valid_d = 1'b1;
            out_p_d     = mpy_p;
            out_flags_d = classify(mpy_p[14:10], mpy_p[9:0]);
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            out_p_q     <= '0;
            out_flags_q <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            out_p_q     <= out_p_d;
            out_flags_q <= out_flags_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_p     = out_p_q;
    assign out_flags = out_flags_q;

`ifdef FEEDER_STATS_EN
    logic [OP_CNT_W-1:0]  op_count_q, op_count_d;
    logic [NAN_CNT_W-1:0] nan_count_q, nan_count_d;
    logic                 handshake;

    // op_count wraps; nan_count saturates
    always_comb begin
        handshake   = out_valid_q && out_ready;
        op_count_d  = op_count_q;
        nan_count_d = nan_count_q;
        if (handshake) begin
            op_count_d = op_count_q + OP_CNT_W'(1);
            if (out_flags_q[3] && (nan_count_q != {NAN_CNT_W{1'b1}})) begin
                nan_count_d = nan_count_q + NAN_CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_count_q  <= '0;
            nan_count_q <= '0;
        end else begin
            op_count_q  <= op_count_d;
            nan_count_q <= nan_count_d;
        end
    end

    assign op_count  = op_count_q;
    assign nan_count = nan_count_q;
`else
    assign op_count  = '0;
    assign nan_count = '0;
`endif

endmodule

// File: tb/tb_fp16_mpy_feeder.sv
// Scoreboard bench for fp16_mpy_feeder with a table-driven stand-in for mpy_top.
`timescale 1ns/1ps
module tb_fp16_mpy_feeder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic [15:0] mpy_a;
    logic [15:0] mpy_b;
    logic [15:0] mpy_p;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_p;
    logic [3:0]  out_flags;
    logic [15:0] op_count;
    logic [7:0]  nan_count;

    typedef struct packed {
        logic [15:0] p;
        logic [3:0]  f;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp    = 0;
    int          n_bad    = 0;
    int          hs_total = 0;
    logic [15:0] exp_op   = '0;
    logic [7:0]  exp_nan  = '0;
    logic        stall_prev = 1'b0;
    logic [15:0] prev_p   = '0;
    logic [3:0]  prev_f   = '0;

    fp16_mpy_feeder #(.DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .mpy_a     (mpy_a),
        .mpy_b     (mpy_b),
        .mpy_p     (mpy_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p),
        .out_flags (out_flags),
        .op_count  (op_count),
        .nan_count (nan_count)
    );

    // Known mpy_top products for the planned vectors; an arbitrary mixing function elsewhere
    function automatic logic [15:0] mpy_model(input logic [15:0] a, input logic [15:0] b);
        case ({a, b})
            32'hBB67_F5CB: return 16'h755C;
            32'h522C_87E6: return 16'h9E18;
            32'h6DA0_AB89: return 16'hDD4C;
            32'h2C52_E687: return 16'hD70D;
            32'hA06D_89AB: return 16'h0019;
            32'h7C00_3C00: return 16'h7C00;
            32'h7E00_3C00: return 16'h7E00;
            32'h0000_3C00: return 16'h0000;
            32'h0001_3C00: return 16'h0001;
            default:       return a ^ {b[7:0], b[15:8]};
        endcase
    endfunction

    function automatic logic [3:0] flags_of(input logic [15:0] p);
        logic [4:0] e;
        logic [9:0] m;
        e = p[14:10];
        m = p[9:0];
        return {(e == 5'h1F) && (m != 0), (e == 5'h1F) && (m == 0),
                (e == 5'h00) && (m == 0), (e == 5'h00) && (m != 0)};
    endfunction

    assign mpy_p = mpy_model(mpy_a, mpy_b);

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, act, want);
        end
    endtask

    // Monitor: scoreboard push/pop, hold stability and counters, sampled mid-cycle
    always @(negedge clk) begin
        if (rst_n) begin
`ifdef FEEDER_STATS_EN
            check("op_count", 32'(op_count), 32'(exp_op));
            check("nan_count", 32'(nan_count), 32'(exp_nan));
`else
            check("op_count_off", 32'(op_count), 32'd0);
            check("nan_count_off", 32'(nan_count), 32'd0);
`endif
            if (stall_prev) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_p", 32'(out_p), 32'(prev_p));
                check("hold_flags", 32'(out_flags), 32'(prev_f));
            end
            if (out_valid && out_ready) begin
                check("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    exp_t e;
                    e = sb_q.pop_front();
                    check("out_p", 32'(out_p), 32'(e.p));
                    check("out_flags", 32'(out_flags), 32'(e.f));
                    if (e.f[3] && exp_nan != 8'hFF) exp_nan = exp_nan + 8'd1;
                end
                exp_op = exp_op + 16'd1;
                hs_total++;
            end
            if (in_valid && in_ready) begin
                exp_t n;
                n.p = mpy_model(in_a, in_b);
                n.f = flags_of(n.p);
                sb_q.push_back(n);
            end
            stall_prev = out_valid && !out_ready;
            prev_p     = out_p;
            prev_f     = out_flags;
        end else begin
            stall_prev = 1'b0;
        end
    end

    // Caller is at posedge+1; returns at posedge+1 after the pair was accepted
    task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        @(negedge clk);
        while (!in_ready && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("push_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while ((sb_q.size() != 0 || out_valid) && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_done", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb_q.delete();
        exp_op  = '0;
        exp_nan = '0;
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    logic [15:0] fa [6];
    logic [15:0] fb [6];
    int          h0;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_a      = '0;
        in_b      = '0;
        fa = '{16'h1234, 16'h4567, 16'h89AB, 16'hCDEF, 16'h0F0F, 16'h5A5A};
        fb = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555, 16'h6666};
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mpy_a", 32'(mpy_a), 32'd0);
        check("rst_mpy_b", 32'(mpy_b), 32'd0);
        check("rst_out_p", 32'(out_p), 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        check("rst_op_count", 32'(op_count), 32'd0);
        check("rst_nan_count", 32'(nan_count), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single operation and one-edge latency
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_a      = 16'hBB67;
        in_b      = 16'hF5CB;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("lat_valid_low", 32'(out_valid), 32'd0);
        check("head_a", 32'(mpy_a), 32'h0000BB67);
        check("head_b", 32'(mpy_b), 32'h0000F5CB);
        @(posedge clk);
        #1;
        check("lat_valid_high", 32'(out_valid), 32'd1);
        check("single_p", 32'(out_p), 32'h0000755C);
        check("single_flags", 32'(out_flags), 32'd0);
        @(posedge clk);
        #1;
        check("single_drop", 32'(out_valid), 32'd0);
`ifdef FEEDER_STATS_EN
        check("single_op_count", 32'(op_count), 32'd1);
`endif

        // Back-to-back burst, one result per cycle then valid drops
        h0 = hs_total;
        push_pair(16'h522C, 16'h87E6);
        push_pair(16'h6DA0, 16'hAB89);
        push_pair(16'h2C52, 16'hE687);
        push_pair(16'hA06D, 16'h89AB);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("burst_rate", 32'(hs_total - h0), 32'd4);
        check("burst_drop", 32'(out_valid), 32'd0);

        // Backpressure until full, then drain
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_pair(fa[i], fb[i]);
        check("full_in_ready", 32'(in_ready), 32'd0);
        check("full_valid", 32'(out_valid), 32'd1);
        check("full_head_p", 32'(out_p), 32'(mpy_model(fa[0], fb[0])));
        in_valid = 1'b1;
        in_a     = fa[5];
        in_b     = fb[5];
        @(posedge clk);
        #1;
        check("full_hold_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        #2;
        check("no_passthru", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("ready_return", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_drain(40);

        // Class flags, checked directly one at a time
        push_pair(16'h7C00, 16'h3C00);
        @(posedge clk);
        #1;
        check("flag_inf", 32'({out_p, out_flags}), 32'h0007C004);
        push_pair(16'h7E00, 16'h3C00);
        @(posedge clk);
        #1;
        check("flag_nan", 32'(out_flags), 32'h8);
        push_pair(16'h0000, 16'h3C00);
        @(posedge clk);
        #1;
        check("flag_zero", 32'({out_p, out_flags}), 32'h00000002);
        push_pair(16'h0001, 16'h3C00);
        @(posedge clk);
        #1;
        check("flag_sub", 32'({out_p, out_flags}), 32'h00000011);
        wait_drain(20);

        // Randomised valid/ready traffic
        for (int i = 0; i < 80; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_a      = 16'($urandom);
            in_b      = 16'($urandom);
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain(40);

        // Reset mid-operation: one product pending and three pairs queued
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_pair(fa[i], fb[i]);
        check("pre_rst_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb_q.delete();
        exp_op  = '0;
        exp_nan = '0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        check("mid_rst_mpy_a", 32'(mpy_a), 32'd0);
        check("mid_rst_op_count", 32'(op_count), 32'd0);
        check("mid_rst_nan_count", 32'(nan_count), 32'd0);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        h0 = hs_total;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
        end
        check("no_stale", 32'(hs_total - h0), 32'd0);
        push_pair(16'h522C, 16'h87E6);
        wait_drain(10);

`ifdef FEEDER_STATS_EN
        // Counter boundaries: op_count wrap and nan_count saturation
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 65536; i++) push_pair(16'(i), 16'h0101);
        wait_drain(10);
        check("op_count_wrap", 32'(op_count), 32'd0);
        for (int i = 0; i < 257; i++) push_pair(16'h7E00, 16'h3C00);
        wait_drain(10);
        check("nan_count_sat", 32'(nan_count), 32'h000000FF);
        check("op_count_after", 32'(op_count), 32'd257);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fp16_mpy_feeder.md
# fp16_mpy_feeder

Sequential front-end for the combinational 16-bit half-precision multiplier (`mpy_top`). It buffers incoming operand pairs in a small FIFO and presents one pair per cycle to the multiplier. Each product is captured in a registered output stage with a valid/ready handshake and IEEE-754 half-precision class flags. Optional statistics counters can be compiled in. The block sits directly upstream of `mpy_top` and downstream of any operand source.

## Interface
- `DEPTH`, 4, operand FIFO depth in pairs; a power of two, 2..16.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous active-low reset.
- `in_valid`  input  1  operand pair offered.
- `in_ready`  output  1  FIFO can accept a pair.
- `in_a`  input  16  operand A, fp16.
- `in_b`  input  16  operand B, fp16.
- `mpy_a`  output  16  to `mpy_top.input_a`; the FIFO head A, or 0 when the FIFO is empty.
- `mpy_b`  output  16  to `mpy_top.input_b`; the FIFO head B, or 0 when the FIFO is empty.
- `mpy_p`  input  16  from `mpy_top.mpy_output`; combinational in the same cycle.
- `out_valid`  output  1  product register holds an unconsumed result.
- `out_ready`  input  1  consumer accepts the product.
- `out_p`  output  16  registered product.
- `out_flags`  output  4  {nan, inf, zero, sub}; registered with `out_p`.
- `op_count`  output  16  completed output handshakes (stats).
- `nan_count`  output  8  NaN products delivered (stats).

## Operation
- Push: on `in_valid && in_ready`, {in_a, in_b} is written at the write pointer, which increments mod DEPTH.
- `in_ready = (count != DEPTH)`. It depends only on the registered count and never on `out_ready`.
- Issue condition: `issue = (count != 0) && (!out_valid || out_ready)`.
- On `issue`: `out_p <= mpy_p`, the flags are computed from `mpy_p`, `out_valid <= 1`, and the read pointer increments.
- Output handshake without issue: `out_valid <= 0`.
- Push and pop in the same cycle leave `count` unchanged; both pointers advance.
- Flags are classified from exponent e = p[14:10] and mantissa m = p[9:0]:
  - nan = (e==31 && m!=0)
  - inf = (e==31 && m==0)
  - zero = (e==0 && m==0)
  - sub = (e==0 && m!=0)
  - At most one flag is set.
- Ordering is strict FIFO: products leave in operand acceptance order, with no drops or duplicates.
- `out_p` and `out_flags` hold stable while `out_valid && !out_ready`.
- The feeder performs no arithmetic of its own; the product value is exactly `mpy_p`.

## Timing
- Reset (asynchronous, immediate) clears:
  - `out_valid`, `out_p`, `out_flags`
  - `count`, both pointers
  - `op_count`, `nan_count`
- After reset, `in_ready = 1`, and `mpy_a` and `mpy_b` are 0.
- FIFO contents are not reset. They are unobservable while `count == 0`.
- Latency: a pair accepted at edge k is issued at edge k+1 if the FIFO was empty and the output register was free. `out_valid` is then high from edge k+1.
- Throughput: one product per cycle while `out_ready` is held high.
- Full FIFO: `in_ready = 0`. A pop at the next edge re-raises `in_ready` from that edge; pass-through in the same cycle is not allowed.
- Empty FIFO with `out_ready` high: `out_valid` drops after the final handshake.
- Reset asserted mid-stream discards all queued pairs and any pending product. No output handshake completes after `rst_n` falls.
- `mpy_p` must settle within one clock period; it is not a multicycle path.

## Configuration
- `FEEDER_STATS_EN` defined:
  - `op_count` increments on each `out_valid && out_ready` and wraps 0xFFFF→0.
  - `nan_count` increments on each handshake with `out_flags[3] == 1` and saturates at 0xFF.
- `FEEDER_STATS_EN` undefined: both counters are absent from the logic, and `op_count` and `nan_count` are tied to 0.

## Test plan
- Single op with `mpy_top` attached: after reset, push BB67×F5CB with `out_ready = 1`. Required: `out_valid` rises one edge after acceptance, `out_p = 755C`, flags = 0000, and `op_count = 1` with stats enabled.
- Back-to-back burst: push 522C×87E6, 6DA0×AB89, 2C52×E687, A06D×89AB on consecutive cycles with `out_ready = 1`. Required: outputs 9E18, DD4C, D70D, 0019, in order, on consecutive cycles.
- Backpressure/full (DEPTH=4): hold `out_ready = 0` and push 6 pairs.
  - Required: the first pair issues into `out_p`, four more fill the FIFO, and `in_ready = 0` on the 6th. `out_p` stays stable.
  - Then raise `out_ready`: `in_ready` returns after the first handshake, all 6 results drain in order, and none are lost.
- Flag classification:
  - 7C00×3C00 → 7C00, flags 0100.
  - 7E00×3C00 → NaN, flags 1000, `nan_count` +1.
  - 0000×3C00 → 0000, flags 0010.
  - 0001×3C00 → 0001, flags 0001.
- Reset mid-operation: with 3 pairs queued and `out_valid = 1`, pulse `rst_n` low between edges. Required: `out_valid`, `count`, `op_count` and `nan_count` read 0 immediately, `in_ready = 1`, and no stale product appears afterwards.
- Counter boundaries with stats enabled: preload via 65536 handshakes → `op_count` wraps to 0; 256 NaN products → `nan_count` holds FF. With stats disabled, both counters read 0 throughout.
